// File: rtl/accel_rr_scheduler_pkg.sv
// Shared constants and FSM state encoding for the accelerator round-robin scheduler.
// Latency: none (definitions only).
// Backpressure: not applicable.
package accel_pkg;

    localparam int ACC_UW     = 2;
    localparam int ACC_VW     = 6;
    localparam int ACC_DW     = 21;
    localparam int ACC_EXP_WR = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } acc_state_t;

endpackage

// File: rtl/accel_rr_scheduler_rr_pick.sv
// Round-robin picker: first set req bit at or above ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module rr_pick
    import accel_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   idx
);

    logic [2*NREQ-1:0] dbl;
    logic [PW:0]       sum;

    // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        dbl = {req, req} >> ptr;
        sum = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                sum = {1'b0, ptr} + (PW+1)'(k);
                if (sum >= (PW+1)'(NREQ)) begin
                    sum = sum - (PW+1)'(NREQ);
                end
                idx = sum[PW-1:0];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/accel_rr_scheduler.sv
// Shares one accelerator among NREQ requesters with round-robin grants; ACCEL_RR_SCHED_WRCHK_EN adds a beat-count check (wr_err).
// Latency: gnt/acc_start 1 cycle after req is sampled in IDLE; done 1 cycle after acc_done in RUN; >=3 cycles between grants.
// Backpressure: none on write beats (forwarded combinationally); requesters wait by holding req until gnt.
module accel_rr_scheduler
    import accel_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int UW     = ACC_UW,
    parameter int VW     = ACC_VW,
    parameter int DW     = ACC_DW
`ifdef ACCEL_RR_SCHED_WRCHK_EN
    ,
    parameter int EXP_WR = ACC_EXP_WR
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*UW-1:0]   u_in,
    input  logic [NREQ*VW-1:0]   v_in,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      wr_valid,
    output logic [DW-1:0]        wr_data,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic                 acc_start,
    output logic [UW-1:0]        acc_u,
    output logic [VW-1:0]        acc_v,
    input  logic                 acc_done,
    input  logic                 acc_wr_req,
    input  logic [DW-1:0]        acc_wr_data
`ifdef ACCEL_RR_SCHED_WRCHK_EN
    ,
    output logic                 wr_err
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    acc_state_t      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic            pick_any;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] owner_oh;
    logic [UW-1:0]   u_arr [NREQ];
    logic [VW-1:0]   v_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign u_arr[i] = u_in[i*UW +: UW];
        assign v_arr[i] = v_in[i*VW +: VW];
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign owner_oh = NREQ'(1) << owner;
    // Beats bypass the registers so a beat arriving with acc_done is never dropped.
    assign wr_valid = (state == RUN && acc_wr_req) ? owner_oh : '0;
    assign wr_data  = acc_wr_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            acc_u     <= '0;
            acc_v     <= '0;
            gnt       <= '0;
            done      <= '0;
            acc_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= LAUNCH;
                        owner     <= pick_idx;
                        acc_u     <= u_arr[pick_idx];
                        acc_v     <= v_arr[pick_idx];
                        gnt       <= NREQ'(1) << pick_idx;
                        acc_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                // acc_done is deliberately ignored here: it may still be high from the previous job.
                LAUNCH: begin
                    gnt       <= '0;
                    acc_start <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    if (acc_done) begin
                        state <= FINISH;
                        done  <= owner_oh;
                    end
                end
                FINISH: begin
                    done  <= '0;
                    busy  <= 1'b0;
                    ptr   <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACCEL_RR_SCHED_WRCHK_EN
    localparam int CW = $clog2(EXP_WR + 1) + 1;

    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_cnt_nxt;

    always_comb begin
        beat_cnt_nxt = beat_cnt;
        if (state == RUN && acc_wr_req && beat_cnt != '1) begin
            beat_cnt_nxt = beat_cnt + CW'(1);
        end
    end

    // The final beat may coincide with acc_done, so judge on the post-beat count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            wr_err   <= 1'b0;
        end else begin
            beat_cnt <= (state == LAUNCH) ? '0 : beat_cnt_nxt;
            wr_err   <= (state == RUN) && acc_done && (beat_cnt_nxt != CW'(EXP_WR));
        end
    end
`endif

endmodule

// File: tb/tb_accel_rr_scheduler.sv
// Randomized and directed bench for accel_rr_scheduler against a transaction-level model.
module tb_accel_rr_scheduler;

    localparam int NREQ = 2;
    localparam int UW   = 2;
    localparam int VW   = 6;
    localparam int DW   = 21;
`ifdef ACCEL_RR_SCHED_WRCHK_EN
    localparam int EXP_WR = 4;
    logic wr_err;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*UW-1:0]  u_in = '0;
    logic [NREQ*VW-1:0]  v_in = '0;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     wr_valid;
    logic [DW-1:0]       wr_data;
    logic [NREQ-1:0]     done;
    logic                busy;
    logic                acc_start;
    logic [UW-1:0]       acc_u;
    logic [VW-1:0]       acc_v;
    logic                acc_done = 1'b0;
    logic                acc_wr_req = 1'b0;
    logic [DW-1:0]       acc_wr_data = '0;

    int tests = 0;
    int fails = 0;

    // Requester and accelerator stimulus state.
    logic [NREQ-1:0] want = '0;
    logic [NREQ-1:0] drop_pend = '0;
    int  plan_beats = 0;
    int  beats_left = 0;
    bit  plan_last = 0, gap_en = 0, noise_en = 0, stale = 0;
    bit  rand_mode = 0, rand_plan = 0, acc_run = 0;

    // Reference model: a job's age since grant, its owner and the rotating pointer.
    int  m_age = -1, m_own = 0, m_ptr = 0, m_cnt = 0;
    bit  m_fin = 0;
    logic [UW-1:0] m_u = '0;
    logic [VW-1:0] m_v = '0;
    int  wait_jobs [NREQ];

    always #5 clk = ~clk;

    accel_rr_scheduler #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .u_in        (u_in),
        .v_in        (v_in),
        .gnt         (gnt),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .done        (done),
        .busy        (busy),
        .acc_start   (acc_start),
        .acc_u       (acc_u),
        .acc_v       (acc_v),
        .acc_done    (acc_done),
        .acc_wr_req  (acc_wr_req),
        .acc_wr_data (acc_wr_data)
`ifdef ACCEL_RR_SCHED_WRCHK_EN
        ,
        .wr_err      (wr_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: requesters and the accelerator react to what they see just after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (drop_pend[i]) begin
                want[i]      = 1'b0;
                drop_pend[i] = 1'b0;
            end else if (gnt[i]) begin
                drop_pend[i] = 1'b1;
            end else if (rand_mode && !want[i] && $urandom_range(3) == 0) begin
                want[i]            = 1'b1;
                u_in[i*UW +: UW]   = UW'($urandom);
                v_in[i*VW +: VW]   = VW'($urandom);
            end
        end
        req = want;
        acc_wr_data = DW'($urandom);
        if (acc_start) begin
            acc_run = 1;
            if (rand_plan) begin
                plan_beats = $urandom_range(5);
                plan_last  = 1'($urandom_range(1));
            end
            beats_left = plan_beats;
            acc_done   = stale | (noise_en & 1'($urandom_range(1)));
            acc_wr_req = noise_en & 1'($urandom_range(1));
        end else if (acc_run) begin
            acc_wr_req = 1'b0;
            acc_done   = 1'b0;
            if (beats_left > 0) begin
                acc_wr_req = gap_en ? ($urandom_range(2) != 0) : 1'b1;
                if (acc_wr_req) beats_left--;
                if (beats_left == 0 && acc_wr_req && plan_last) acc_done = 1'b1;
            end else begin
                acc_done = gap_en ? ($urandom_range(1) == 1) : 1'b1;
            end
            if (acc_done) acc_run = 0;
        end else begin
            acc_done   = stale | (noise_en & 1'($urandom_range(1)));
            acc_wr_req = noise_en & 1'($urandom_range(1));
        end
        #1;
    endtask

    task automatic clear_stim();
        want = '0; drop_pend = '0; req = '0;
        acc_run = 0; acc_done = 1'b0; acc_wr_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_stim();
        repeat (2) cycle();
        rst = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && (want != 0 || busy); i++) cycle();
        chk({tag, "_drained"}, 32'(want == 0 && !busy), 1);
    endtask

    // Waits for the grant, then follows the job to its done pulse.
    task automatic run_job(input string tag, input logic [NREQ-1:0] exp_gnt, input int exp_beats);
        int  beats = 0, stray = 0;
        bit  prev_ad = 0;
        for (int i = 0; i < 20 && gnt == 0; i++) cycle();
        chk({tag, "_gnt"}, gnt, exp_gnt);
        chk({tag, "_start"}, acc_start, 1);
        for (int i = 0; i < 40; i++) begin
            prev_ad = acc_done;
            cycle();
            if (i == 0) chk({tag, "_no_early_done"}, done, 0);
            if (done != 0) break;
            if (wr_valid != 0) begin
                beats++;
                if (wr_valid != exp_gnt) stray++;
            end
        end
        chk({tag, "_done"}, done, exp_gnt);
        chk({tag, "_done_after_acc_done"}, 32'(prev_ad), 1);
        chk({tag, "_beats"}, beats, exp_beats);
        chk({tag, "_stray_beats"}, stray, 0);
`ifdef ACCEL_RR_SCHED_WRCHK_EN
        chk({tag, "_wr_err"}, wr_err, 32'(exp_beats != EXP_WR));
`endif
    endtask

    // Per-cycle comparison against the model, then advance the model on this cycle's inputs.
    initial begin : compare
        logic [NREQ-1:0] own_oh;
        int w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_age = -1; m_fin = 0; m_ptr = 0; m_own = 0; m_cnt = 0;
                m_u = '0; m_v = '0;
                foreach (wait_jobs[i]) wait_jobs[i] = 0;
                chk("rst_ctrl", {gnt, done, wr_valid, acc_start, busy}, 0);
                chk("rst_operands", {acc_u, acc_v}, 0);
            end else begin
                own_oh = NREQ'(1) << m_own;
                chk("m_gnt", gnt, (m_age == 0) ? own_oh : '0);
                chk("m_start", acc_start, 32'(m_age == 0));
                chk("m_busy", busy, 32'(m_age >= 0));
                chk("m_done", done, m_fin ? own_oh : '0);
                chk("m_wr_valid", wr_valid, (m_age >= 1 && !m_fin && acc_wr_req) ? own_oh : '0);
                chk("m_wr_data", wr_data, acc_wr_data);
                chk("m_acc_u", acc_u, m_u);
                chk("m_acc_v", acc_v, m_v);
`ifdef ACCEL_RR_SCHED_WRCHK_EN
                chk("m_wr_err", wr_err, 32'(m_fin && m_cnt != EXP_WR));
`endif
                if (gnt != 0) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (gnt[i]) begin
                            chk("fair_wait", 32'(wait_jobs[i] < NREQ), 1);
                            wait_jobs[i] = 0;
                        end else if (req[i]) begin
                            wait_jobs[i]++;
                        end
                    end
                end
                if (m_fin) begin
                    m_fin = 0;
                    m_age = -1;
                    m_ptr = (m_own + 1) % NREQ;
                end else if (m_age < 0) begin
                    if (req != 0) begin
                        w = m_ptr;
                        while (!req[w]) w = (w + 1) % NREQ;
                        m_own = w;
                        m_u   = u_in[w*UW +: UW];
                        m_v   = v_in[w*VW +: VW];
                        m_age = 0;
                        m_cnt = 0;
                    end
                end else if (m_age == 0) begin
                    m_age = 1;
                end else begin
                    if (acc_wr_req) m_cnt++;
                    if (acc_done) m_fin = 1;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached after %0d comparisons, expected summary first", tests);
        $fatal(1);
    end

    initial begin : main
        logic [NREQ-1:0] exp_g;
        int  ngr;
        bit  saw_done;

        repeat (3) cycle();
        chk("reset_gnt", gnt, 0);
        chk("reset_busy", busy, 0);
        chk("reset_acc_u", acc_u, 0);
        chk("reset_acc_v", acc_v, 0);
        rst = 1'b1;
        repeat (2) cycle();

        // Single requester, four back-to-back beats.
        u_in[1:0] = 2'b10;
        v_in[5:0] = 6'h2A;
        want[0] = 1'b1;
        plan_beats = 4; plan_last = 0;
        run_job("single", 2'b01, 4);
        chk("single_acc_u", acc_u, 2'b10);
        chk("single_acc_v", acc_v, 6'h2A);
        drain("single");

        // Both requesters keep asking; pointer starts at 0 after reset.
        do_reset();
        plan_beats = 1;
        ngr = 0;
        saw_done = 1;
        for (int i = 0; i < 80 && ngr < 4; i++) begin
            want = '1;
            cycle();
            if (done != 0) saw_done = 1;
            if (gnt != 0) begin
                exp_g = (ngr % 2 == 0) ? 2'b01 : 2'b10;
                chk("contend_gnt", gnt, exp_g);
                chk("contend_after_done", 32'(saw_done), 1);
                saw_done = 0;
                ngr++;
            end
        end
        chk("contend_count", ngr, 4);
        drain("contend");

        // acc_done stuck high before and during launch.
        stale = 1;
        u_in[3:2] = 2'b01;
        v_in[11:6] = 6'h15;
        want[1] = 1'b1;
        plan_beats = 2;
        run_job("stale", 2'b10, 2);
        stale = 0;
        drain("stale");

        want[0] = 1'b1;
        plan_beats = 3;
        run_job("three", 2'b01, 3);
        drain("three");

        // Last beat coincides with acc_done; owner 0 leaves the pointer at 1.
        want[0] = 1'b1;
        plan_beats = 2; plan_last = 1;
        run_job("lastbeat", 2'b01, 2);
        plan_last = 0;
        drain("lastbeat");

        // Reset while a job from requester 1 is streaming beats.
        want[1] = 1'b1;
        plan_beats = 5;
        for (int i = 0; i < 20 && gnt == 0; i++) cycle();
        repeat (2) cycle();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_ctrl", {gnt, done, wr_valid, acc_start, busy}, 0);
        chk("midrst_acc_u", acc_u, 0);
        chk("midrst_acc_v", acc_v, 0);
        clear_stim();
        repeat (2) cycle();
        rst = 1'b1;
        want = '1;
        plan_beats = 1;
        run_job("post_rst", 2'b01, 1);
        drain("post_rst");

        // Random traffic with gaps, stale done and stray write requests.
        rand_mode = 1; rand_plan = 1; gap_en = 1; noise_en = 1;
        repeat (3000) cycle();
        rand_mode = 0; noise_en = 0;
        drain("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
